// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage memory access controller. Converts load/store requests into
//   timed external-SRAM cycles or memory-mapped UART accesses and stalls the
//   pipeline until each access reaches its DONE cycle.
//
//   Build option: MEM_CTRL_UART_EN
//     defined   - 0xBF00 is the UART data register, 0xBF01 the status register
//     undefined - every address goes to SRAM, UART outputs tied low
//
//   Ports
//     clk_50MHz, rst          clock, synchronous active-high reset
//     mem_rd, mem_wr          load/store request (store wins if both high)
//     mem_addr, mem_wdata     word address, store data
//     mem_rdata               load result (to MEM/WB n_mw_RAM_data)
//     mem_stall               pipeline freeze
//     ram_*                   external SRAM address/data/strobes (active-low)
//     uart_*                  UART handshake: tx strobe/data, rx ack/data/status
module mem_access_ctrl #(
  parameter int unsigned SRAM_AW = 18
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [15:0]        mem_addr,
  input  logic [15:0]        mem_wdata,
  output logic [15:0]        mem_rdata,
  output logic               mem_stall,
  output logic [SRAM_AW-1:0] ram_addr,
  output logic [15:0]        ram_dq_o,
  input  logic [15:0]        ram_dq_i,
  output logic               ram_dq_oe,
  output logic               ram_ce_n,
  output logic               ram_oe_n,
  output logic               ram_we_n,
  input  logic               uart_tx_ready,
  input  logic               uart_rx_valid,
  input  logic [7:0]         uart_rx_data,
  output logic               uart_tx_valid,
  output logic [7:0]         uart_tx_data,
  output logic               uart_rx_ack
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, WR3, DONE} state_e;

  state_e               state_q, state_d;
  logic [SRAM_AW-1:0]   ram_addr_q;
  logic [15:0]          ram_dq_o_q;
  logic                 ram_ce_n_q, ram_oe_n_q, ram_we_n_q, ram_dq_oe_q;
  logic [15:0]          rdata_q;

  logic                 uart_data_hit, uart_stat_hit, uart_hit;
  logic [15:0]          uart_rd_word;
  logic                 req, sram_start, uart_start;

`ifdef MEM_CTRL_UART_EN
  logic                 tx_valid_q, rx_ack_q;
  logic [7:0]           tx_data_q;

  assign uart_data_hit = (mem_addr == 16'hBF00);
  assign uart_stat_hit = (mem_addr == 16'hBF01);
  assign uart_rd_word  = uart_data_hit ? {8'h00, uart_rx_data}
                                       : {14'b0, uart_rx_valid, uart_tx_ready};

  // Strobes are set on the IDLE->DONE edge so they cover exactly the DONE cycle.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      rx_ack_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= uart_start && mem_wr && uart_data_hit;
      rx_ack_q   <= uart_start && !mem_wr && uart_data_hit;
      if (uart_start && mem_wr && uart_data_hit) tx_data_q <= mem_wdata[7:0];
    end
  end

  assign uart_tx_valid = tx_valid_q;
  assign uart_rx_ack   = rx_ack_q;
  assign uart_tx_data  = tx_data_q;
`else
  logic unused_uart;

  assign uart_data_hit = 1'b0;
  assign uart_stat_hit = 1'b0;
  assign uart_rd_word  = '0;
  assign unused_uart   = ^{uart_tx_ready, uart_rx_valid, uart_rx_data};
  assign uart_tx_valid = 1'b0;
  assign uart_rx_ack   = 1'b0;
  assign uart_tx_data  = '0;
`endif

  assign uart_hit   = uart_data_hit | uart_stat_hit;
  assign req        = mem_rd | mem_wr;
  assign sram_start = (state_q == IDLE) && req && !uart_hit;
  assign uart_start = (state_q == IDLE) && req && uart_hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_wr)      state_d = uart_hit ? DONE : WR1;
        else if (mem_rd) state_d = uart_hit ? DONE : RD1;
      end
      RD1:     state_d = RD2;
      RD2:     state_d = DONE;
      WR1:     state_d = WR2;
      WR2:     state_d = WR3;
      WR3:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM strobes are registered from the next state, so each one is a clean
  // flop output aligned with the state it belongs to. Address and write data
  // are captured once at IDLE exit, so we_n never falls while they move.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      ram_dq_o_q  <= '0;
      ram_ce_n_q  <= 1'b1;
      ram_oe_n_q  <= 1'b1;
      ram_we_n_q  <= 1'b1;
      ram_dq_oe_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ram_ce_n_q  <= !(state_d inside {RD1, RD2, WR1, WR2, WR3});
      ram_oe_n_q  <= !(state_d inside {RD1, RD2});
      ram_we_n_q  <= (state_d != WR2);
      ram_dq_oe_q <= (state_d inside {WR1, WR2, WR3});
      if (sram_start)           ram_addr_q <= SRAM_AW'(mem_addr);
      if (sram_start && mem_wr) ram_dq_o_q <= mem_wdata;
      if (state_q == RD2)                rdata_q <= ram_dq_i;
      else if (uart_start && !mem_wr)    rdata_q <= uart_rd_word;
    end
  end

  assign mem_stall = req & (state_q != DONE) & ~rst;
  assign mem_rdata = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_dq_o  = ram_dq_o_q;
  assign ram_dq_oe = ram_dq_oe_q;
  assign ram_ce_n  = ram_ce_n_q;
  assign ram_oe_n  = ram_oe_n_q;
  assign ram_we_n  = ram_we_n_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a 64K-word SRAM model.
// UART-specific scenarios follow the MEM_CTRL_UART_EN build option.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_stall;
  logic [17:0] ram_addr;
  logic [15:0] ram_dq_o, ram_dq_i;
  logic        ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n;
  logic        uart_tx_ready, uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_tx_valid, uart_rx_ack;
  logic [7:0]  uart_tx_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.SRAM_AW(18)) dut (
    .clk_50MHz(clk), .rst(rst),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_i(ram_dq_i), .ram_dq_oe(ram_dq_oe),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .uart_tx_ready(uart_tx_ready), .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .uart_rx_ack(uart_rx_ack)
  );

  always #10 clk = ~clk;

  // SRAM model with a bench-side preload port
  logic [15:0] sram [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr, pre_data;

  assign ram_dq_i = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[15:0]] : 16'h0000;

  always @(posedge clk) begin
    if (pre_en) sram[pre_addr] <= pre_data;
    else if (!ram_ce_n && !ram_we_n && ram_dq_oe) sram[ram_addr[15:0]] <= ram_dq_o;
  end

  // Bus monitor: monotonic event counters sampled on the falling edge
  int          we_low_cnt = 0, wr_viol = 0, tx_cnt = 0, rx_cnt = 0, rd_cnt = 0;
  logic [7:0]  tx_seen = 8'h00;
  logic [17:0] rd_addr_seen = '0;
  logic [17:0] prev_addr = '0;
  logic [15:0] prev_dq = '0;
  logic        prev_we_n = 1'b1;

  always @(negedge clk) begin
    if (!ram_we_n) we_low_cnt++;
    if (uart_tx_valid) begin tx_cnt++; tx_seen = uart_tx_data; end
    if (uart_rx_ack) rx_cnt++;
    if (!ram_ce_n && !ram_oe_n) begin rd_cnt++; rd_addr_seen = ram_addr; end
    if (!ram_we_n && (ram_addr !== prev_addr || ram_dq_o !== prev_dq || !ram_dq_oe || ram_ce_n))
      wr_viol++;
    if (!prev_we_n && ram_we_n && (ram_addr !== prev_addr || ram_dq_o !== prev_dq || !ram_dq_oe))
      wr_viol++;
    prev_addr = ram_addr;
    prev_dq   = ram_dq_o;
    prev_we_n = ram_we_n;
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Presents a request right after the next rising edge and returns at the
  // falling edge of the first cycle with stall low (the DONE cycle).
  task automatic run_access(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [15:0] d, output int stalls, output bit timed_out);
    @(posedge clk); #1;
    mem_rd = rd; mem_wr = wr; mem_addr = a; mem_wdata = d;
    stalls = 0; timed_out = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!mem_stall) begin timed_out = 1'b0; break; end
      stalls++;
    end
  endtask

  task automatic end_access();
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = 16'h1234; mem_wdata = 16'h0;
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mem_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0000", mem_rdata); end
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", mem_stall); end
    n_checks++; if ({ram_ce_n, ram_oe_n, ram_we_n} !== 3'b111) begin n_fail++; $display("FAIL rst_strobes got=%b exp=111", {ram_ce_n, ram_oe_n, ram_we_n}); end
    n_checks++; if (ram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_dq_oe got=%b exp=0", ram_dq_oe); end
    n_checks++; if (ram_dq_o !== 16'h0000) begin n_fail++; $display("FAIL rst_dq_o got=%h exp=0000", ram_dq_o); end
    n_checks++; if (ram_addr !== 18'h00000) begin n_fail++; $display("FAIL rst_addr got=%h exp=00000", ram_addr); end
    n_checks++; if ({uart_tx_valid, uart_rx_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_uart_strobes got=%b exp=00", {uart_tx_valid, uart_rx_ack}); end
    n_checks++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got=%h exp=00", uart_tx_data); end
    mem_rd = 1'b0; rst = 1'b0;
  endtask

  task automatic test_sram_load();
    int st; bit to;
    preload(16'h1234, 16'hBEEF);
    run_access(1'b1, 1'b0, 16'h1234, 16'h0, st, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL load_timeout got=stalled exp=done"); end
    n_checks++; if (st != 3) begin n_fail++; $display("FAIL load_stall_cycles got=%0d exp=3", st); end
    n_checks++; if (mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL load_rdata got=%h exp=beef", mem_rdata); end
    n_checks++; if ({ram_ce_n, ram_oe_n, ram_dq_oe} !== 3'b110) begin n_fail++; $display("FAIL load_done_strobes got=%b exp=110", {ram_ce_n, ram_oe_n, ram_dq_oe}); end
    end_access();
    n_checks++; if (rd_addr_seen !== 18'h01234) begin n_fail++; $display("FAIL load_ram_addr got=%h exp=01234", rd_addr_seen); end
  endtask

  task automatic test_sram_store();
    int st; bit to; int we0, v0;
    we0 = we_low_cnt; v0 = wr_viol;
    run_access(1'b0, 1'b1, 16'h0040, 16'hA5A5, st, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL store_timeout got=stalled exp=done"); end
    n_checks++; if (st != 4) begin n_fail++; $display("FAIL store_stall_cycles got=%0d exp=4", st); end
    end_access();
    @(posedge clk); #1;
    n_checks++; if (we_low_cnt - we0 != 1) begin n_fail++; $display("FAIL store_we_pulses got=%0d exp=1", we_low_cnt - we0); end
    n_checks++; if (wr_viol != v0) begin n_fail++; $display("FAIL store_addr_data_hold got=%0d exp=0 violations", wr_viol - v0); end
    n_checks++; if (sram[16'h0040] !== 16'hA5A5) begin n_fail++; $display("FAIL store_model got=%h exp=a5a5", sram[16'h0040]); end
    n_checks++; if (mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL store_rdata_held got=%h exp=beef", mem_rdata); end
  endtask

  task automatic test_back_to_back();
    int st1, st2; bit to1, to2;
    preload(16'h0100, 16'h2468);
    run_access(1'b1, 1'b0, 16'h0100, 16'h0, st1, to1);
    n_checks++; if (to1 || st1 != 3) begin n_fail++; $display("FAIL b2b_load_stall got=%0d exp=3", st1); end
    n_checks++; if (mem_rdata !== 16'h2468) begin n_fail++; $display("FAIL b2b_load_rdata got=%h exp=2468", mem_rdata); end
    // store presented on the DONE edge of the load, with no idle gap
    run_access(1'b0, 1'b1, 16'h0200, 16'h1357, st2, to2);
    n_checks++; if (to2 || st2 != 4) begin n_fail++; $display("FAIL b2b_store_stall got=%0d exp=4", st2); end
    end_access();
    n_checks++; if (sram[16'h0200] !== 16'h1357) begin n_fail++; $display("FAIL b2b_store_model got=%h exp=1357", sram[16'h0200]); end
    n_checks++; if (mem_rdata !== 16'h2468) begin n_fail++; $display("FAIL b2b_rdata_held got=%h exp=2468", mem_rdata); end
  endtask

  task automatic test_simultaneous();
    int st; bit to; int we0, rd0;
    we0 = we_low_cnt; rd0 = rd_cnt;
    run_access(1'b1, 1'b1, 16'h0300, 16'h0F0F, st, to);
    n_checks++; if (to || st != 4) begin n_fail++; $display("FAIL both_stall got=%0d exp=4", st); end
    end_access();
    n_checks++; if (we_low_cnt - we0 != 1) begin n_fail++; $display("FAIL both_we_pulses got=%0d exp=1", we_low_cnt - we0); end
    n_checks++; if (rd_cnt != rd0) begin n_fail++; $display("FAIL both_read_cycles got=%0d exp=0", rd_cnt - rd0); end
    n_checks++; if (sram[16'h0300] !== 16'h0F0F) begin n_fail++; $display("FAIL both_model got=%h exp=0f0f", sram[16'h0300]); end
    n_checks++; if (mem_rdata !== 16'h2468) begin n_fail++; $display("FAIL both_rdata_held got=%h exp=2468", mem_rdata); end
  endtask

`ifdef MEM_CTRL_UART_EN
  task automatic test_uart_status();
    int st; bit to; int rx0;
    rx0 = rx_cnt;
    uart_tx_ready = 1'b1; uart_rx_valid = 1'b1;
    run_access(1'b1, 1'b0, 16'hBF01, 16'h0, st, to);
    n_checks++; if (to || st != 1) begin n_fail++; $display("FAIL ustat_stall got=%0d exp=1", st); end
    n_checks++; if (mem_rdata !== 16'h0003) begin n_fail++; $display("FAIL ustat_rdata got=%h exp=0003", mem_rdata); end
    end_access();
    uart_tx_ready = 1'b0; uart_rx_valid = 1'b1;
    run_access(1'b1, 1'b0, 16'hBF01, 16'h0, st, to);
    n_checks++; if (mem_rdata !== 16'h0002) begin n_fail++; $display("FAIL ustat_rx_only got=%h exp=0002", mem_rdata); end
    end_access();
    n_checks++; if (rx_cnt != rx0) begin n_fail++; $display("FAIL ustat_no_ack got=%0d exp=0", rx_cnt - rx0); end
  endtask

  task automatic test_uart_data();
    int st; bit to; int tx0, rx0, we0;
    tx0 = tx_cnt; rx0 = rx_cnt; we0 = we_low_cnt;
    run_access(1'b0, 1'b1, 16'hBF00, 16'h1241, st, to);
    n_checks++; if (to || st != 1) begin n_fail++; $display("FAIL utx_stall got=%0d exp=1", st); end
    end_access();
    @(posedge clk); #1;
    n_checks++; if (tx_cnt - tx0 != 1) begin n_fail++; $display("FAIL utx_pulses got=%0d exp=1", tx_cnt - tx0); end
    n_checks++; if (tx_seen !== 8'h41) begin n_fail++; $display("FAIL utx_data got=%h exp=41", tx_seen); end
    n_checks++; if (we_low_cnt != we0) begin n_fail++; $display("FAIL utx_no_sram got=%0d exp=0", we_low_cnt - we0); end
    uart_rx_data = 8'h7E;
    run_access(1'b1, 1'b0, 16'hBF00, 16'h0, st, to);
    n_checks++; if (to || st != 1) begin n_fail++; $display("FAIL urx_stall got=%0d exp=1", st); end
    n_checks++; if (mem_rdata !== 16'h007E) begin n_fail++; $display("FAIL urx_rdata got=%h exp=007e", mem_rdata); end
    end_access();
    @(posedge clk); #1;
    n_checks++; if (rx_cnt - rx0 != 1) begin n_fail++; $display("FAIL urx_ack_pulses got=%0d exp=1", rx_cnt - rx0); end
    tx0 = tx_cnt;
    run_access(1'b0, 1'b1, 16'hBF01, 16'hFFFF, st, to);
    n_checks++; if (to || st != 1) begin n_fail++; $display("FAIL ustat_wr_stall got=%0d exp=1", st); end
    end_access();
    n_checks++; if (tx_cnt != tx0 || mem_rdata !== 16'h007E) begin n_fail++; $display("FAIL ustat_wr_ignored got=%0d/%h exp=0/007e", tx_cnt - tx0, mem_rdata); end
  endtask
`else
  task automatic test_uart_disabled();
    int st; bit to; int tx0;
    tx0 = tx_cnt;
    uart_tx_ready = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h7E;
    preload(16'hBF01, 16'h5A5A);
    run_access(1'b1, 1'b0, 16'hBF01, 16'h0, st, to);
    n_checks++; if (to || st != 3) begin n_fail++; $display("FAIL nouart_rd_stall got=%0d exp=3", st); end
    n_checks++; if (mem_rdata !== 16'h5A5A) begin n_fail++; $display("FAIL nouart_rdata got=%h exp=5a5a", mem_rdata); end
    end_access();
    n_checks++; if (rd_addr_seen !== 18'h0BF01) begin n_fail++; $display("FAIL nouart_ram_addr got=%h exp=0bf01", rd_addr_seen); end
    run_access(1'b0, 1'b1, 16'hBF00, 16'h1241, st, to);
    n_checks++; if (to || st != 4) begin n_fail++; $display("FAIL nouart_wr_stall got=%0d exp=4", st); end
    end_access();
    n_checks++; if (sram[16'hBF00] !== 16'h1241) begin n_fail++; $display("FAIL nouart_wr_model got=%h exp=1241", sram[16'hBF00]); end
    n_checks++; if (tx_cnt != tx0 || uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL nouart_tx_tied got=%0d/%h exp=0/00", tx_cnt - tx0, uart_tx_data); end
  endtask
`endif

  task automatic test_reset_mid_write();
    int st; bit to;
    mem_wr = 1'b1; mem_addr = 16'h0077; mem_wdata = 16'hCAFE;
    @(posedge clk); #1;   // WR1
    @(posedge clk); #1;   // WR2
    n_checks++; if (ram_we_n !== 1'b0) begin n_fail++; $display("FAIL rstwr_in_wr2 got=%b exp=0", ram_we_n); end
    rst = 1'b1;
    #5;
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rstwr_stall_gated got=%b exp=0", mem_stall); end
    @(posedge clk); #1;
    n_checks++; if ({ram_we_n, ram_ce_n, ram_dq_oe} !== 3'b110) begin n_fail++; $display("FAIL rstwr_strobes got=%b exp=110", {ram_we_n, ram_ce_n, ram_dq_oe}); end
    n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rstwr_stall got=%b exp=0", mem_stall); end
    rst = 1'b0; mem_wr = 1'b0;
    run_access(1'b1, 1'b0, 16'h1234, 16'h0, st, to);
    n_checks++; if (to || st != 3) begin n_fail++; $display("FAIL rstwr_load_stall got=%0d exp=3", st); end
    n_checks++; if (mem_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rstwr_load_rdata got=%h exp=beef", mem_rdata); end
    end_access();
  endtask

  initial begin
    test_reset();
    test_sram_load();
    test_sram_store();
    test_back_to_back();
    test_simultaneous();
`ifdef MEM_CTRL_UART_EN
    test_uart_status();
    test_uart_data();
`else
    test_uart_disabled();
`endif
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage memory access controller. It turns the MEM stage's load/store requests into timed external-SRAM cycles and memory-mapped UART accesses, and stalls the pipeline for the duration of each access. It returns load data on `mem_rdata`, which feeds the `n_mw_RAM_data` input of the MEM/WB pipeline register. It is the producer of what MEM/WB latches for writeback.

## Interface
Parameters:
- `SRAM_AW`, 18: external SRAM address width. The 16-bit `mem_addr` is zero-extended to this width.

Ports:
- `clk_50MHz` in 1: the only clock.
- `rst` in 1: synchronous reset, active-high. Reset is synchronous and active-high on `clk_50MHz`.
- `mem_rd` in 1: load request from the MEM stage, held until `mem_stall` falls.
- `mem_wr` in 1: store request, held the same way. Has priority over `mem_rd` if both are high.
- `mem_addr` in 16: word address.
- `mem_wdata` in 16: store data.
- `mem_rdata` out 16: load result, routed to `n_mw_RAM_data`.
- `mem_stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM while high.
- `ram_addr` out SRAM_AW: SRAM address.
- `ram_dq_o` out 16: SRAM write data.
- `ram_dq_i` in 16: SRAM read data.
- `ram_dq_oe` out 1: data-bus output enable for the top-level tristate.
- `ram_ce_n`, `ram_oe_n`, `ram_we_n` out 1 each: SRAM strobes, active-low.
- `uart_tx_ready` in 1: transmitter can accept a byte.
- `uart_rx_valid` in 1: a received byte is available.
- `uart_rx_data` in 8: the received byte.
- `uart_tx_valid` out 1: one-cycle transmit strobe.
- `uart_tx_data` out 8: byte to transmit.
- `uart_rx_ack` out 1: one-cycle strobe that pops the received byte.

## Operation
- FSM states: IDLE, RD1, RD2, WR1, WR2, WR3, DONE.
- **Address decode:**
  - `mem_addr` 0xBF00 is the UART data register.
  - `mem_addr` 0xBF01 is the UART status register.
  - Every other address goes to SRAM.
- **IDLE.** Requests are sampled only in this state.
  - SRAM store: go to WR1.
  - SRAM load: go to RD1.
  - UART access: go directly to DONE and perform the UART action on that same edge.
  - No request: stay in IDLE.
- **Read path:**
  - RD1: drive `ram_addr`, `ram_ce_n=0`, `ram_oe_n=0`.
  - RD2: hold the strobes; on exit, register `ram_dq_i` into `mem_rdata`.
  - Then go to DONE.
- **Write path:**
  - WR1: drive address, `ram_dq_o=mem_wdata`, `ram_dq_oe=1`, `ram_ce_n=0`.
  - WR2: `ram_we_n=0`.
  - WR3: `ram_we_n=1`; address and data still held.
  - Then go to DONE.
- **DONE:** all SRAM strobes inactive, `ram_dq_oe=0`; next state is IDLE.
- `mem_stall = (mem_rd | mem_wr) & (state != DONE) & ~rst`.
- **UART data-register access:**
  - Read of 0xBF00 registers `mem_rdata={8'h00, uart_rx_data}` and pulses `uart_rx_ack`.
  - Write of 0xBF00 registers `uart_tx_data=mem_wdata[7:0]` and pulses `uart_tx_valid`.
  - Both strobes are registered, high for exactly the DONE cycle.
- **UART status read:** reading 0xBF01 returns `mem_rdata={14'b0, uart_rx_valid, uart_tx_ready}`.
- **Write-only/read-only side effects:**
  - A write to 0xBF01 is ignored, but it still takes the DONE cycle.
  - A store leaves `mem_rdata` unchanged.
- `mem_rdata` holds its value until the next load completes.

## Timing
- Request first seen in IDLE at edge T:
  - SRAM load: `mem_stall` high for cycles T..T+2, low in DONE at T+3; `mem_rdata` valid from T+3.
  - SRAM store: stall high T..T+3, DONE at T+4; `we_n` low only during T+2.
  - UART access: stall high for cycle T only, DONE at T+1.
- After DONE, the pipeline advances on the DONE edge. The next request is sampled in IDLE on the following cycle, so back-to-back accesses are each separated by one DONE cycle.
- **Reset values** (synchronous; reset taken at any state, including mid-write):
  - State IDLE.
  - `mem_rdata=0`.
  - `ram_ce_n=ram_oe_n=ram_we_n=1`.
  - `ram_dq_oe=0`, `ram_dq_o=0`, `ram_addr=0`.
  - `uart_tx_valid=uart_rx_ack=0`, `uart_tx_data=0`.
  - `mem_stall=0` while `rst` is high.
- **Input-stability rules:**
  - `ram_we_n` never falls in the same cycle `ram_addr` or `ram_dq_o` changes.
  - `mem_addr`/`mem_wdata`/`mem_rd`/`mem_wr` must stay stable while `mem_stall` is high. Changes during an access are ignored; values are latched at IDLE exit.
- Simultaneous `mem_rd & mem_wr`: handled as a store.

## Configuration
- `MEM_CTRL_UART_EN`
  - Defined: 0xBF00/0xBF01 decode to the UART as described above.
  - Undefined: all addresses go to SRAM; `uart_tx_valid`, `uart_rx_ack` and `uart_tx_data` are tied to 0 and the UART inputs are unused.

## Test plan
- **SRAM load:** `mem_rd=1`, `mem_addr=0x1234`, model returns 0xBEEF.
  - `ram_addr=0x01234`.
  - Stall high 3 cycles.
  - `mem_rdata=0xBEEF` with stall low.
- **SRAM store:** `mem_wr=1`, `addr=0x0040`, `wdata=0xA5A5`.
  - Single `we_n` low pulse, with addr and data stable one cycle before and after.
  - Stall high 4 cycles; the model then holds 0xA5A5.
- **UART status:** read 0xBF01 with `tx_ready=1`, `rx_valid=1`.
  - `mem_rdata=0x0003`; stall high 1 cycle.
  - With the macro undefined, the access goes to SRAM addr 0x0BF01.
- **UART data:**
  - Write 0xBF00 with `wdata=0x1241`: one `uart_tx_valid` pulse, `tx_data=0x41`.
  - Read 0xBF00 with `rx_data=0x7E`: `mem_rdata=0x007E`, one `uart_rx_ack` pulse.
- **Reset during WR2:** assert `rst` for 1 cycle.
  - Next edge: `we_n=1`, `dq_oe=0`, stall 0, state IDLE.
  - A subsequent load completes normally.
- **Back-to-back and simultaneous:**
  - A load immediately followed by a store completes both with one DONE cycle between.
  - `mem_rd=mem_wr=1` performs a store only.
